// File: rtl/muldiv_sequencer.sv
// Multi-cycle sequencer for the M-extension multiplier and divider: stalls EX, applies sign and special-case rules.
// Defining MULDIV_FUSE_EN adds a one-entry operand/result cache that answers repeated ops without starting a unit.
//   state    | meaning
//   IDLE     | waiting for an M-op from EX
//   MUL_BUSY | multiplier running
//   DIV_BUSY | divider running
//   DONE     | result presented for one cycle
//   DRAIN    | flushed op still in a unit; its result will be discarded
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_req_valid,
    input  logic [2:0]         i_req_op,
    input  logic [WIDTH-1:0]   i_req_a,
    input  logic [WIDTH-1:0]   i_req_b,
    input  logic               i_flush,
    output logic               o_stall,
    output logic               o_resp_valid,
    output logic [WIDTH-1:0]   o_resp_result,
    output logic               o_mul_start,
    output logic [WIDTH-1:0]   o_mul_a,
    output logic [WIDTH-1:0]   o_mul_b,
    output logic               o_mul_a_signed,
    output logic               o_mul_b_signed,
    input  logic               i_mul_done,
    input  logic [2*WIDTH-1:0] i_mul_prod,
    output logic               o_div_start,
    output logic [WIDTH-1:0]   o_div_a,
    output logic [WIDTH-1:0]   o_div_b,
    input  logic               i_div_done,
    input  logic [WIDTH-1:0]   i_div_quot,
    input  logic [WIDTH-1:0]   i_div_rem
);
    typedef enum logic [2:0] {
        ST_IDLE, ST_MUL_BUSY, ST_DIV_BUSY, ST_DONE, ST_DRAIN
    } state_t;

    localparam logic [WIDTH-1:0] ONES    = '1;
    localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             r_state, w_state_nxt;
    logic [2:0]         r_op;
    logic               r_neg_q, r_neg_r;
    logic [WIDTH-1:0]   r_result;
    logic               r_mul_start, r_div_start;
    logic [WIDTH-1:0]   r_mul_a, r_mul_b, r_div_a, r_div_b;
    logic               r_mul_a_signed, r_mul_b_signed;

    logic               w_accept, w_op_div, w_op_rem, w_sdiv, w_b_zero, w_ovf, w_special;
    logic               w_a_neg, w_b_neg, w_mul_asgn, w_mul_bsgn, w_hit, w_stall;
    logic [WIDTH-1:0]   w_special_res, w_abs_a, w_abs_b, w_hit_res;
    logic [WIDTH-1:0]   w_q_adj, w_r_adj, w_div_res, w_mul_res;

    assign w_accept   = i_req_valid & ~i_flush;
    assign w_op_div   = i_req_op[2];
    assign w_op_rem   = i_req_op[1];
    assign w_sdiv     = w_op_div & ~i_req_op[0];
    assign w_b_zero   = (i_req_b == '0);
    assign w_ovf      = w_sdiv & (i_req_a == INT_MIN) & (i_req_b == ONES);
    assign w_special  = w_op_div & (w_b_zero | w_ovf);
    assign w_special_res = w_b_zero ? (w_op_rem ? i_req_a : ONES)
                                    : (w_op_rem ? '0 : INT_MIN);
    assign w_a_neg    = w_sdiv & i_req_a[WIDTH-1];
    assign w_b_neg    = w_sdiv & i_req_b[WIDTH-1];
    assign w_abs_a    = w_a_neg ? -i_req_a : i_req_a;
    assign w_abs_b    = w_b_neg ? -i_req_b : i_req_b;
    assign w_mul_asgn = (i_req_op == 3'b001) | (i_req_op == 3'b010);
    assign w_mul_bsgn = (i_req_op == 3'b001);

    assign w_q_adj   = r_neg_q ? -i_div_quot : i_div_quot;
    assign w_r_adj   = r_neg_r ? -i_div_rem : i_div_rem;
    assign w_div_res = r_op[1] ? w_r_adj : w_q_adj;
    assign w_mul_res = (r_op == 3'b000) ? i_mul_prod[WIDTH-1:0] : i_mul_prod[2*WIDTH-1:WIDTH];

`ifdef MULDIV_FUSE_EN
    // Class: 1_0_u for div/rem (u = unsigned), 0_as_bs for multiplies.
    logic               r_c_valid;
    logic [WIDTH-1:0]   r_c_a, r_c_b, r_c_lo, r_c_hi;
    logic [2:0]         r_c_class;
    logic [2:0]         w_class;

    assign w_class   = w_op_div ? {2'b10, i_req_op[0]} : {1'b0, w_mul_asgn, w_mul_bsgn};
    assign w_hit     = r_c_valid & (i_req_a == r_c_a) & (i_req_b == r_c_b) &
                       ((i_req_op == 3'b000) ? ~r_c_class[2] : (r_c_class == w_class));
    assign w_hit_res = w_op_div ? (w_op_rem ? r_c_hi : r_c_lo)
                                : ((i_req_op == 3'b000) ? r_c_lo : r_c_hi);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_c_valid <= 1'b0;
            r_c_a     <= '0;
            r_c_b     <= '0;
            r_c_lo    <= '0;
            r_c_hi    <= '0;
            r_c_class <= '0;
        end else if (r_state == ST_IDLE && w_accept && !w_special && !w_hit) begin
            r_c_valid <= 1'b0;
            r_c_a     <= i_req_a;
            r_c_b     <= i_req_b;
            r_c_class <= w_class;
        end else if (r_state == ST_MUL_BUSY && i_mul_done && !i_flush) begin
            r_c_valid <= 1'b1;
            {r_c_hi, r_c_lo} <= i_mul_prod;
        end else if (r_state == ST_DIV_BUSY && i_div_done && !i_flush) begin
            r_c_valid <= 1'b1;
            r_c_lo    <= w_q_adj;
            r_c_hi    <= w_r_adj;
        end else if (w_state_nxt == ST_DRAIN && r_state != ST_DRAIN) begin
            r_c_valid <= 1'b0;
        end
    end
`else
    assign w_hit     = 1'b0;
    assign w_hit_res = '0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_stall      = 1'b0;
        o_resp_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_stall = i_req_valid;
                if (w_accept)
                    w_state_nxt = (w_special || w_hit) ? ST_DONE :
                                  (w_op_div ? ST_DIV_BUSY : ST_MUL_BUSY);
            end
            ST_MUL_BUSY: begin
                w_stall = 1'b1;
                if (i_mul_done)   w_state_nxt = i_flush ? ST_IDLE : ST_DONE;
                else if (i_flush) w_state_nxt = ST_DRAIN;
            end
            ST_DIV_BUSY: begin
                w_stall = 1'b1;
                if (i_div_done)   w_state_nxt = i_flush ? ST_IDLE : ST_DONE;
                else if (i_flush) w_state_nxt = ST_DRAIN;
            end
            ST_DONE: begin
                o_resp_valid = ~i_flush;
                w_state_nxt  = ST_IDLE;
            end
            ST_DRAIN: begin
                w_stall = i_req_valid;
                if (r_op[2] ? i_div_done : i_mul_done) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Stall must read 0 while reset is held even if EX still presents a request.
    assign o_stall = w_stall & i_rst_n;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op           <= '0;
            r_neg_q        <= 1'b0;
            r_neg_r        <= 1'b0;
            r_result       <= '0;
            r_mul_start    <= 1'b0;
            r_div_start    <= 1'b0;
            r_mul_a        <= '0;
            r_mul_b        <= '0;
            r_mul_a_signed <= 1'b0;
            r_mul_b_signed <= 1'b0;
            r_div_a        <= '0;
            r_div_b        <= '0;
        end else begin
            r_mul_start <= 1'b0;
            r_div_start <= 1'b0;
            case (r_state)
                ST_IDLE: if (w_accept) begin
                    r_op    <= i_req_op;
                    r_neg_q <= w_a_neg ^ w_b_neg;
                    r_neg_r <= w_a_neg;
                    if (w_special) begin
                        r_result <= w_special_res;
                    end else if (w_hit) begin
                        r_result <= w_hit_res;
                    end else if (w_op_div) begin
                        r_div_start <= 1'b1;
                        r_div_a     <= w_abs_a;
                        r_div_b     <= w_abs_b;
                    end else begin
                        r_mul_start    <= 1'b1;
                        r_mul_a        <= i_req_a;
                        r_mul_b        <= i_req_b;
                        r_mul_a_signed <= w_mul_asgn;
                        r_mul_b_signed <= w_mul_bsgn;
                    end
                end
                ST_MUL_BUSY: if (i_mul_done && !i_flush) r_result <= w_mul_res;
                ST_DIV_BUSY: if (i_div_done && !i_flush) r_result <= w_div_res;
                default: ;
            endcase
        end
    end

    assign o_resp_result  = r_result;
    assign o_mul_start    = r_mul_start;
    assign o_mul_a        = r_mul_a;
    assign o_mul_b        = r_mul_b;
    assign o_mul_a_signed = r_mul_a_signed;
    assign o_mul_b_signed = r_mul_b_signed;
    assign o_div_start    = r_div_start;
    assign o_div_a        = r_div_a;
    assign o_div_b        = r_div_b;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: table of directed ops plus flush/drain and async-reset sequences.
module tb_muldiv_sequencer;
    localparam int W = 32;
`ifdef MULDIV_FUSE_EN
    localparam bit FUSE = 1'b1;
`else
    localparam bit FUSE = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           req_valid, flush;
    logic [2:0]     req_op;
    logic [W-1:0]   req_a, req_b;
    logic           stall, resp_valid;
    logic [W-1:0]   resp_result;
    logic           mul_start, mul_a_signed, mul_b_signed, mul_done;
    logic [W-1:0]   mul_a, mul_b;
    logic [2*W-1:0] mul_prod;
    logic           div_start, div_done;
    logic [W-1:0]   div_a, div_b, div_quot, div_rem;

    int checks = 0;
    int failures = 0;
    int mul_t = 0, div_t = 0, mul_lat = 3, div_lat = 2;

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .i_req_op(req_op),
        .i_req_a(req_a), .i_req_b(req_b), .i_flush(flush),
        .o_stall(stall), .o_resp_valid(resp_valid), .o_resp_result(resp_result),
        .o_mul_start(mul_start), .o_mul_a(mul_a), .o_mul_b(mul_b),
        .o_mul_a_signed(mul_a_signed), .o_mul_b_signed(mul_b_signed),
        .i_mul_done(mul_done), .i_mul_prod(mul_prod),
        .o_div_start(div_start), .o_div_a(div_a), .o_div_b(div_b),
        .i_div_done(div_done), .i_div_quot(div_quot), .i_div_rem(div_rem)
    );

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a, b;
        logic [63:0]  prod;
        logic [W-1:0] quot, rem, exp_res;
        int           unit;      // 0 none, 1 multiplier, 2 divider
        logic [W-1:0] opa, opb;
        logic         asg, bsg;
        int           resp_cyc;
    } vec_t;

    function automatic vec_t mk(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b, logic [63:0] prod,
                                logic [W-1:0] q, logic [W-1:0] r, logic [W-1:0] res, int unit,
                                logic [W-1:0] opa, logic [W-1:0] opb, logic asg, logic bsg, int rc);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.prod = prod; v.quot = q; v.rem = r; v.exp_res = res;
        v.unit = unit; v.opa = opa; v.opb = opb; v.asg = asg; v.bsg = bsg; v.resp_cyc = rc;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0h expected=%0h", name, idx, act, exp);
        end
    endtask

    // Unit stubs: done pulses lat cycles after the start pulse is seen.
    task automatic stub_update();
        mul_done = 1'b0;
        div_done = 1'b0;
        if (mul_start) mul_t = mul_lat;
        else if (mul_t > 0) begin mul_t--; if (mul_t == 0) mul_done = 1'b1; end
        if (div_start) div_t = div_lat;
        else if (div_t > 0) begin div_t--; if (div_t == 0) div_done = 1'b1; end
    endtask

    task automatic run_op(input vec_t v, input int idx);
        int cyc, resp_cyc, nstall, nmul, ndiv, start_cyc;
        logic [W-1:0] res, opa, opb;
        logic asg, bsg;
        cyc = 0; resp_cyc = -1; nstall = 0; nmul = 0; ndiv = 0; start_cyc = -1;
        res = '0; opa = '0; opb = '0; asg = 1'b0; bsg = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_op = v.op; req_a = v.a; req_b = v.b;
        mul_prod = v.prod; div_quot = v.quot; div_rem = v.rem;
        while (resp_cyc < 0 && cyc < 40) begin
            #1;
            if (stall) nstall++;
            if (mul_start) begin
                nmul++; start_cyc = cyc; opa = mul_a; opb = mul_b; asg = mul_a_signed; bsg = mul_b_signed;
            end
            if (div_start) begin
                ndiv++; start_cyc = cyc; opa = div_a; opb = div_b;
            end
            if (resp_valid) begin resp_cyc = cyc; res = resp_result; end
            stub_update();
            if (resp_cyc >= 0) req_valid = 1'b0;
            cyc++;
            @(negedge clk);
        end
        #1;
        check("resp_one_cycle", idx, {63'd0, resp_valid}, 64'd0);
        check("resp_cycle", idx, resp_cyc, v.resp_cyc);
        check("result", idx, res, v.exp_res);
        check("stall_cycles", idx, nstall, v.resp_cyc);
        check("mul_starts", idx, nmul, (v.unit == 1) ? 1 : 0);
        check("div_starts", idx, ndiv, (v.unit == 2) ? 1 : 0);
        if (v.unit != 0) begin
            check("start_cycle", idx, start_cyc, 1);
            check("unit_op_a", idx, opa, v.opa);
            check("unit_op_b", idx, opb, v.opb);
        end
        if (v.unit == 1) check("mul_signs", idx, {asg, bsg}, {v.asg, v.bsg});
    endtask

    vec_t vecs[15];

    initial begin
        int resp_cyc, mstart_cyc, nstall;
        logic [W-1:0] res;
        rst_n = 1'b0; req_valid = 1'b0; flush = 1'b0; req_op = '0; req_a = '0; req_b = '0;
        mul_done = 1'b0; div_done = 1'b0; mul_prod = '0; div_quot = '0; div_rem = '0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_stall", 0, stall, 0);
        check("rst_resp_valid", 0, resp_valid, 0);
        check("rst_resp_result", 0, resp_result, 0);
        check("rst_starts", 0, {mul_start, div_start}, 0);
        check("rst_operands", 0, {mul_a, mul_b, div_a | div_b}, 0);
        check("rst_signed", 0, {mul_a_signed, mul_b_signed}, 0);
        rst_n = 1'b1;

        vecs[0]  = mk(3'b000, 32'd7, 32'hFFFFFFFD, 64'h00000006_FFFFFFEB, 0, 0, 32'hFFFFFFEB, 1, 32'd7, 32'hFFFFFFFD, 0, 0, 5);
        vecs[1]  = mk(3'b001, 32'hFFFFFFFE, 32'd3, 64'hFFFFFFFF_FFFFFFFA, 0, 0, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 32'd3, 1, 1, 5);
        vecs[2]  = mk(3'b010, 32'hFFFFFFFF, 32'd2, 64'hFFFFFFFF_FFFFFFFE, 0, 0, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 32'd2, 1, 0, 5);
        vecs[3]  = mk(3'b011, 32'h80000000, 32'd4, 64'h00000002_00000000, 0, 0, 32'd2, 1, 32'h80000000, 32'd4, 0, 0, 5);
        vecs[4]  = mk(3'b100, 32'hFFFFFFEC, 32'd3, 0, 32'd6, 32'd2, 32'hFFFFFFFA, 2, 32'd20, 32'd3, 0, 0, 4);
        vecs[5]  = mk(3'b110, 32'hFFFFFFEC, 32'd3, 0, 32'd6, 32'd2, 32'hFFFFFFFE, FUSE ? 0 : 2,
                      32'd20, 32'd3, 0, 0, FUSE ? 1 : 4);
        vecs[6]  = mk(3'b101, 32'd5, 32'd0, 0, 0, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 1);
        vecs[7]  = mk(3'b110, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0, 32'd0, 0, 0, 0, 0, 0, 1);
        vecs[8]  = mk(3'b100, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0, 32'h80000000, 0, 0, 0, 0, 0, 1);
        vecs[9]  = mk(3'b111, 32'd5, 32'd0, 0, 0, 0, 32'd5, 0, 0, 0, 0, 0, 1);
        vecs[10] = mk(3'b100, 32'd100, 32'hFFFFFFF9, 0, 32'd14, 32'd2, 32'hFFFFFFF2, 2, 32'd100, 32'd7, 0, 0, 4);
        vecs[11] = mk(3'b110, 32'hFFFFFF9C, 32'd7, 0, 32'd14, 32'd2, 32'hFFFFFFFE, 2, 32'd100, 32'd7, 0, 0, 4);
        vecs[12] = mk(3'b101, 32'hFFFFFFEC, 32'd3, 0, 32'h5555554E, 32'd2, 32'h5555554E, 2, 32'hFFFFFFEC, 32'd3, 0, 0, 4);
        vecs[13] = mk(3'b100, 32'd100, 32'd7, 0, 32'd14, 32'd2, 32'd14, 2, 32'd100, 32'd7, 0, 0, 4);
        vecs[14] = mk(3'b110, 32'd100, 32'd7, 0, 32'd14, 32'd2, 32'd2, FUSE ? 0 : 2,
                      32'd100, 32'd7, 0, 0, FUSE ? 1 : 4);

        for (int i = 0; i < 15; i++) run_op(vecs[i], i);

        // Flush during the second DIV_BUSY cycle; a MUL waits behind the drain.
        div_lat = 5;
        resp_cyc = -1; mstart_cyc = -1; nstall = 0; res = '0;
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'b100; req_a = 32'd50; req_b = 32'd6; div_quot = 32'd8; div_rem = 32'd2;
        for (int c = 0; c < 30 && resp_cyc < 0; c++) begin
            if (c == 2) flush = 1'b1;
            if (c == 3) begin
                flush = 1'b0; req_op = 3'b000; req_a = 32'd7; req_b = 32'd3; mul_prod = 64'd21;
            end
            #1;
            if (c >= 3 && c <= 6 && stall) nstall++;
            if (mul_start && mstart_cyc < 0) mstart_cyc = c;
            if (resp_valid) begin resp_cyc = c; res = resp_result; end
            stub_update();
            if (resp_cyc >= 0) req_valid = 1'b0;
            @(negedge clk);
        end
        check("drain_stall", 0, nstall, 4);
        check("drain_mul_start_cycle", 0, mstart_cyc, 8);
        check("drain_resp_cycle", 0, resp_cyc, 12);
        check("drain_result", 0, res, 21);
        div_lat = 2;

        // Asynchronous reset while the multiplier is busy.
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'b000; req_a = 32'd3; req_b = 32'd5; mul_prod = 64'd15;
        #1 stub_update();
        @(negedge clk);
        #1;
        check("pre_rst_mul_start", 0, mul_start, 1);
        check("pre_rst_stall", 0, stall, 1);
        rst_n = 1'b0; req_valid = 1'b0;
        mul_t = 0; div_t = 0; mul_done = 1'b0; div_done = 1'b0;
        #1;
        check("async_rst_outputs", 0, {stall, resp_valid, mul_start}, 0);
        check("async_rst_mul_a", 0, mul_a, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op(mk(3'b101, 32'd9, 32'd2, 0, 32'd4, 32'd1, 32'd4, 2, 32'd9, 32'd2, 0, 0, 4), 99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
